// File: rtl/sep7_pkg.sv
// sep7_pkg -- shared types and constants for the two-digit 7-segment display.
//
// Contents:
//   seg7_t           7-bit segment pattern, bit order {g,f,e,d,c,b,a}
//   bcd_t            packed tens/units BCD pair
//   SEG_0..SEG_F     hex glyphs in active-low form (lit segment = 0)
//   SEG_BLANK        all segments off, active-low form
//   apply_polarity   converts an active-low pattern to the requested polarity
package sep7_pkg;

  typedef logic [6:0] seg7_t;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] units;
  } bcd_t;

  localparam seg7_t SEG_0     = 7'h40;
  localparam seg7_t SEG_1     = 7'h79;
  localparam seg7_t SEG_2     = 7'h24;
  localparam seg7_t SEG_3     = 7'h30;
  localparam seg7_t SEG_4     = 7'h19;
  localparam seg7_t SEG_5     = 7'h12;
  localparam seg7_t SEG_6     = 7'h02;
  localparam seg7_t SEG_7     = 7'h78;
  localparam seg7_t SEG_8     = 7'h00;
  localparam seg7_t SEG_9     = 7'h10;
  localparam seg7_t SEG_A     = 7'h08;
  localparam seg7_t SEG_B     = 7'h03;
  localparam seg7_t SEG_C     = 7'h46;
  localparam seg7_t SEG_D     = 7'h21;
  localparam seg7_t SEG_E     = 7'h06;
  localparam seg7_t SEG_F     = 7'h0E;
  localparam seg7_t SEG_BLANK = 7'h7F;

  // All constants above are stored active-low; active-high is the inverse.
  function automatic seg7_t apply_polarity(input seg7_t pattern, input bit active_low);
    return active_low ? pattern : ~pattern;
  endfunction

endpackage

// File: rtl/led7_decoder.sv
// led7_decoder -- combinational hex nibble to 7-segment decoder.
//
// Parameters:
//   SEG_ACTIVE_LOW  1 = lit segment driven 0 (common anode), 0 = lit driven 1
// Ports:
//   digit  input  [3:0]  nibble to display (0..15, shown as 0-9, A,b,C,d,E,F)
//   seg    output [6:0]  segment pattern {g,f,e,d,c,b,a}
module led7_decoder
  import sep7_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] digit,
  output seg7_t      seg
);

  seg7_t pattern_al;

  always_comb begin
    pattern_al = SEG_BLANK;
    case (digit)
      4'h0: pattern_al = SEG_0;
      4'h1: pattern_al = SEG_1;
      4'h2: pattern_al = SEG_2;
      4'h3: pattern_al = SEG_3;
      4'h4: pattern_al = SEG_4;
      4'h5: pattern_al = SEG_5;
      4'h6: pattern_al = SEG_6;
      4'h7: pattern_al = SEG_7;
      4'h8: pattern_al = SEG_8;
      4'h9: pattern_al = SEG_9;
      4'hA: pattern_al = SEG_A;
      4'hB: pattern_al = SEG_B;
      4'hC: pattern_al = SEG_C;
      4'hD: pattern_al = SEG_D;
      4'hE: pattern_al = SEG_E;
      4'hF: pattern_al = SEG_F;
      default: pattern_al = SEG_BLANK;
    endcase
  end

  assign seg = apply_polarity(pattern_al, SEG_ACTIVE_LOW);

endmodule

// File: rtl/separate_led7_decoder.sv
// separate_led7_decoder -- splits a 6-bit binary count into BCD tens/units
// and drives two 7-segment patterns, all four outputs registered together.
//
// Parameters:
//   SEG_ACTIVE_LOW  1 = lit segment driven 0 (common anode), 0 = lit driven 1
// Ports:
//   clk_50    input       system clock, rising edge
//   rst_n     input       asynchronous active-low reset (digits 0, segments blank)
//   value     input [5:0] binary count 0..63
//   digit_lo  output[3:0] BCD units digit
//   digit_hi  output[3:0] BCD tens digit
//   seg_lo    output[6:0] segment pattern for digit_lo, {g,f,e,d,c,b,a}
//   seg_hi    output[6:0] segment pattern for digit_hi, {g,f,e,d,c,b,a}
// Build option:
//   BLANK_LEADING_ZERO_EN  when defined, seg_hi is blank while the tens digit
//                          is 0 (digit_hi still reads 0, seg_lo unaffected).
module separate_led7_decoder
  import sep7_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk_50,
  input  logic       rst_n,
  input  logic [5:0] value,
  output logic [3:0] digit_lo,
  output logic [3:0] digit_hi,
  output seg7_t      seg_lo,
  output seg7_t      seg_hi
);

  localparam seg7_t BLANK = apply_polarity(SEG_BLANK, SEG_ACTIVE_LOW);

  bcd_t  bcd;
  seg7_t dec_lo;
  seg7_t dec_hi;
  seg7_t seg_hi_next;

  // Single-cycle split; quotient is at most 6 and remainder at most 9, so the
  // casts only drop bits that are always zero.
  always_comb begin
    bcd.tens  = 4'(value / 6'd10);
    bcd.units = 4'(value % 6'd10);
  end

  led7_decoder #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec_lo (
    .digit (bcd.units),
    .seg   (dec_lo)
  );

  led7_decoder #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec_hi (
    .digit (bcd.tens),
    .seg   (dec_hi)
  );

  always_comb begin
    seg_hi_next = dec_hi;
`ifdef BLANK_LEADING_ZERO_EN
    if (bcd.tens == 4'd0) seg_hi_next = BLANK;
`else
    seg_hi_next = dec_hi;
`endif
  end

  // Digits and segments come from the same sample and share one register
  // stage, so they can never disagree on any cycle.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      digit_lo <= 4'd0;
      digit_hi <= 4'd0;
      seg_lo   <= BLANK;
      seg_hi   <= BLANK;
    end else begin
      digit_lo <= bcd.units;
      digit_hi <= bcd.tens;
      seg_lo   <= dec_lo;
      seg_hi   <= seg_hi_next;
    end
  end

endmodule

// File: tb/tb_separate_led7_decoder.sv
// tb_separate_led7_decoder -- self-checking bench for separate_led7_decoder.
// Two instances share clock, reset and value: u_dut (active-low segments) and
// u_dut_ah (SEG_ACTIVE_LOW=0). Expected words are pushed when a value is
// driven and popped after the next rising edge.
// Word layout: {digit_hi, digit_lo, seg_hi, seg_lo, seg_hi_ah, seg_lo_ah}.
module tb_separate_led7_decoder;

  localparam int W = 36;

  // ---------------- clock / reset ----------------
  logic       clk_50 = 1'b0;
  logic       rst_n  = 1'b1;
  logic [5:0] value  = 6'd0;

  always #10 clk_50 = ~clk_50;

  logic [3:0] digit_lo, digit_hi, digit_lo_ah, digit_hi_ah;
  logic [6:0] seg_lo, seg_hi, seg_lo_ah, seg_hi_ah;

  separate_led7_decoder u_dut (
    .clk_50   (clk_50),
    .rst_n    (rst_n),
    .value    (value),
    .digit_lo (digit_lo),
    .digit_hi (digit_hi),
    .seg_lo   (seg_lo),
    .seg_hi   (seg_hi)
  );

  separate_led7_decoder #(.SEG_ACTIVE_LOW(1'b0)) u_dut_ah (
    .clk_50   (clk_50),
    .rst_n    (rst_n),
    .value    (value),
    .digit_lo (digit_lo_ah),
    .digit_hi (digit_hi_ah),
    .seg_lo   (seg_lo_ah),
    .seg_hi   (seg_hi_ah)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [6:0] seg_al(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
      4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
      4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
      4'd9: return 7'h10;  4'd10: return 7'h08; 4'd11: return 7'h03;
      4'd12: return 7'h46; 4'd13: return 7'h21; 4'd14: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [W-1:0] model(input int v);
    logic [3:0] t, u;
    logic [6:0] sh, sl;
    t  = 4'(v / 10);
    u  = 4'(v % 10);
    sh = seg_al(t);
    sl = seg_al(u);
`ifdef BLANK_LEADING_ZERO_EN
    if (t == 4'd0) sh = 7'h7F;
`endif
    return {t, u, sh, sl, ~sh, ~sl};
  endfunction

  function automatic logic [W-1:0] observed();
    return {digit_hi, digit_lo, seg_hi, seg_lo, seg_hi_ah, seg_lo_ah};
  endfunction

  localparam logic [W-1:0] RESET_WORD = {4'd0, 4'd0, 7'h7F, 7'h7F, 7'h00, 7'h00};

  // ---------------- driver tasks / scenarios ----------------
  task automatic test_reset();
    logic [W-1:0] obs;
    #3 rst_n = 1'b0;
    #2;
    obs = observed();
    checks++;
    if (obs !== RESET_WORD) begin
      errors++;
      $display("FAIL reset_async got=%h exp=%h", obs, RESET_WORD);
    end
    repeat (2) @(posedge clk_50);
    #1;
    obs = observed();
    checks++;
    if (obs !== RESET_WORD) begin
      errors++;
      $display("FAIL reset_held got=%h exp=%h", obs, RESET_WORD);
    end
    // First edge after release must already decode.
    @(negedge clk_50);
    rst_n = 1'b1;
    value = 6'd25;
    exp_q.push_back(model(25));
    @(posedge clk_50);
    #1;
    obs = observed();
    checks++;
    if (obs !== exp_q[0]) begin
      errors++;
      $display("FAIL reset_first_decode got=%h exp=%h", obs, exp_q[0]);
    end
    void'(exp_q.pop_front());
  endtask

  task automatic test_decode();
    @(negedge clk_50);
    value = 6'd59;
    exp_q.push_back(model(59));
    @(posedge clk_50);
    #1;
    checks++;
    if (observed() !== exp_q[0]) begin
      errors++;
      $display("FAIL decode_59 got=%h exp=%h", observed(), exp_q[0]);
    end
    void'(exp_q.pop_front());
    checks++;
    if ({digit_hi, digit_lo, seg_hi, seg_lo} !== {4'd5, 4'd9, 7'h12, 7'h10}) begin
      errors++;
      $display("FAIL decode_59_const got=%h/%h/%h/%h exp=5/9/12/10",
               digit_hi, digit_lo, seg_hi, seg_lo);
    end
  endtask

  task automatic test_wrap();
    int vals[3] = '{59, 0, 63};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_50);
      value = 6'(vals[i]);
      exp_q.push_back(model(vals[i]));
      @(posedge clk_50);
      #1;
      checks++;
      if (observed() !== exp_q[0]) begin
        errors++;
        $display("FAIL wrap_v%0d got=%h exp=%h", vals[i], observed(), exp_q[0]);
      end
      void'(exp_q.pop_front());
      if (vals[i] == 0) begin
        checks++;
        if ({digit_hi, digit_lo, seg_lo} !== {4'd0, 4'd0, 7'h40}) begin
          errors++;
          $display("FAIL wrap_zero got=%h/%h/%h exp=0/0/40", digit_hi, digit_lo, seg_lo);
        end
`ifndef BLANK_LEADING_ZERO_EN
        checks++;
        if (seg_hi !== 7'h40) begin
          errors++;
          $display("FAIL wrap_zero_seg_hi got=%h exp=40", seg_hi);
        end
`endif
      end
      if (vals[i] == 63) begin
        checks++;
        if ({digit_hi, digit_lo, seg_hi, seg_lo} !== {4'd6, 4'd3, 7'h02, 7'h30}) begin
          errors++;
          $display("FAIL bound_63 got=%h/%h/%h/%h exp=6/3/02/30",
                   digit_hi, digit_lo, seg_hi, seg_lo);
        end
      end
    end
  endtask

  task automatic test_leading_zero();
`ifdef BLANK_LEADING_ZERO_EN
    @(negedge clk_50);
    value = 6'd7;
    @(posedge clk_50);
    #1;
    checks++;
    if ({digit_hi, seg_hi, seg_lo} !== {4'd0, 7'h7F, 7'h78}) begin
      errors++;
      $display("FAIL blank_lz_7 got=%h/%h/%h exp=0/7F/78", digit_hi, seg_hi, seg_lo);
    end
    @(negedge clk_50);
    value = 6'd10;
    @(posedge clk_50);
    #1;
    checks++;
    if ({seg_hi, seg_lo} !== {7'h79, 7'h40}) begin
      errors++;
      $display("FAIL blank_lz_10 got=%h/%h exp=79/40", seg_hi, seg_lo);
    end
`else
    @(negedge clk_50);
    value = 6'd5;
    @(posedge clk_50);
    #1;
    checks++;
    if ({digit_hi, seg_hi, seg_lo} !== {4'd0, 7'h40, 7'h12}) begin
      errors++;
      $display("FAIL no_blank_05 got=%h/%h/%h exp=0/40/12", digit_hi, seg_hi, seg_lo);
    end
`endif
  endtask

  task automatic test_polarity();
    @(negedge clk_50);
    value = 6'd8;
    exp_q.push_back(model(8));
    @(posedge clk_50);
    #1;
    checks++;
    if (observed() !== exp_q[0]) begin
      errors++;
      $display("FAIL polarity_8 got=%h exp=%h", observed(), exp_q[0]);
    end
    void'(exp_q.pop_front());
    checks++;
    if (seg_lo_ah !== 7'h7F) begin
      errors++;
      $display("FAIL polarity_seg_lo got=%h exp=7F", seg_lo_ah);
    end
`ifndef BLANK_LEADING_ZERO_EN
    checks++;
    if (seg_hi_ah !== 7'h3F) begin
      errors++;
      $display("FAIL polarity_seg_hi got=%h exp=3F", seg_hi_ah);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int v;
    // Full sweep followed by random back-to-back values.
    for (int i = 0; i < 64 + 40; i++) begin
      v = (i < 64) ? i : int'($urandom_range(0, 63));
      @(negedge clk_50);
      value = 6'(v);
      exp_q.push_back(model(v));
      @(posedge clk_50);
      #1;
      checks++;
      if (observed() !== exp_q[0]) begin
        errors++;
        $display("FAIL sweep_v%0d got=%h exp=%h", v, observed(), exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_reset_midstream();
    @(negedge clk_50);
    value = 6'd42;
    #4 rst_n = 1'b0;
    #1;
    checks++;
    if (observed() !== RESET_WORD) begin
      errors++;
      $display("FAIL mid_reset_async got=%h exp=%h", observed(), RESET_WORD);
    end
    @(posedge clk_50);
    #1;
    checks++;
    if (observed() !== RESET_WORD) begin
      errors++;
      $display("FAIL mid_reset_discard got=%h exp=%h", observed(), RESET_WORD);
    end
    @(negedge clk_50);
    rst_n = 1'b1;
    value = 6'd17;
    exp_q.push_back(model(17));
    @(posedge clk_50);
    #1;
    checks++;
    if (observed() !== exp_q[0]) begin
      errors++;
      $display("FAIL mid_reset_recover got=%h exp=%h", observed(), exp_q[0]);
    end
    void'(exp_q.pop_front());
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_decode();
    test_wrap();
    test_leading_zero();
    test_polarity();
    test_back_to_back();
    test_reset_midstream();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/separate_led7_decoder.md
SEPARATE_LED7_DECODER -- requirements
Module: separate_led7_decoder

Interface
REQ-001 SHALL have parameter SEG_ACTIVE_LOW, default 1, meaning 1 = a lit segment is driven 0 (common-anode), 0 = a lit segment is driven 1.
REQ-002 SHALL have port clk_50, input, 1 bit: single system clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port value, input, 6 bits: unsigned binary count, 0..63.
REQ-005 SHALL have port digit_lo, output, 4 bits: BCD units digit of value.
REQ-006 SHALL have port digit_hi, output, 4 bits: BCD tens digit of value.
REQ-007 SHALL have port seg_lo, output, 7 bits: segment pattern for digit_lo, bit order {g,f,e,d,c,b,a}.
REQ-008 SHALL have port seg_hi, output, 7 bits: segment pattern for digit_hi, same bit order.

Function
REQ-009 SHALL compute tens = value / 10 and units = value % 10, so 0..63 gives tens 0..6 and units 0..9.
REQ-010 SHALL register digit_lo, digit_hi, seg_lo and seg_hi on the same clk_50 edge, giving exactly 1 cycle of latency from value to all four outputs.
REQ-011 SHALL keep all four outputs mutually consistent: they always reflect the same sampled value, with no cycle where digits and segments disagree.
REQ-012 SHALL, with SEG_ACTIVE_LOW=1, decode digits 0..9 to 40,79,24,30,19,12,02,78,00,10 (hex).
REQ-013 SHALL decode nibbles 10..15 to A,b,C,d,E,F, which are 08,03,46,21,06,0E (hex) with SEG_ACTIVE_LOW=1; these codes are unreachable from value but are required of the decoder.
REQ-014 SHALL represent the blank pattern as all segments off: 7F with SEG_ACTIVE_LOW=1, 00 with SEG_ACTIVE_LOW=0.
REQ-015 SHALL, with SEG_ACTIVE_LOW=0, output the bitwise inverse of every active-low pattern.
REQ-016 SHALL use purely combinational division and modulo logic, with no multi-cycle iteration, so a new value every cycle yields a new result every cycle.

Reset
REQ-017 SHALL, while rst_n=0 and independent of clk_50, immediately drive digit_lo=0, digit_hi=0, seg_lo=blank and seg_hi=blank.
REQ-018 SHALL produce a valid decode on the first rising clk_50 edge after rst_n deasserts.
REQ-019 SHALL, on reset asserted mid-stream, discard the pending sample; outputs go blank at once.

Configuration
REQ-020 SHALL, when macro BLANK_LEADING_ZERO_EN is defined, drive seg_hi to blank whenever tens=0; digit_hi still reads 0 and seg_lo is unaffected.
REQ-021 SHALL, when BLANK_LEADING_ZERO_EN is undefined, always decode seg_hi normally, so value 5 shows "05".

Structure
REQ-022 SHALL take the segment constants SEG_0..SEG_9, SEG_A..SEG_F and SEG_BLANK (active-low form) and the 7-bit segment type from a shared package, sep7_pkg.
REQ-023 SHALL implement decoding in one combinational sub-module, led7_decoder (4-bit in, 7-bit out, with polarity parameter), instantiated twice.
REQ-024 SHALL keep the binary-to-BCD split inline in the top module; no separate split sub-module.

Verification
REQ-025 SHALL verify reset: rst_n=0 asynchronously mid-cycle, then digits=0 and seg_lo=seg_hi=7F immediately, without waiting for a clock edge.
REQ-026 SHALL verify decode: value=59 -> after 1 edge digit_hi=5, digit_lo=9, seg_hi=12, seg_lo=10.
REQ-027 SHALL verify wrap and boundaries: value 59 then 0 on consecutive cycles -> outputs 5/9 then 0/0 with seg 40/40 (macro off); value=63 -> 6/3, seg_hi=02, seg_lo=30.
REQ-028 SHALL verify the macro: with BLANK_LEADING_ZERO_EN defined, value=7 -> seg_hi=7F, seg_lo=78, digit_hi=0; value=10 -> seg_hi=79, seg_lo=40.
REQ-029 SHALL verify polarity: SEG_ACTIVE_LOW=0, value=8 -> seg_lo=7F, seg_hi=3F (macro off).
REQ-030 SHALL verify the sweep: all values 0..63 driven back to back -> each output equals the golden model exactly 1 cycle later, with no stale-digit/segment mismatch.
